// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Configurable inter-stage register for the five-stage MIPS pipeline
//   (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries instruction, PC, N_DATA operand
//   channels, a control sideband, branch-delay flag, exception code and a
//   valid bit. Supports hold (stall), bubble insertion that keeps PC/BD for
//   precise exceptions, and exception/interrupt flush.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   req                flush (exception/interrupt), PC_out <- FLUSH_PC
//   en                 advance: latch all inputs
//   bubble             insert NOP but keep PC_in/bd_in
//   instr_in/PC_in/data_in/sig_in/bd_in/exc_in/valid_in   stage inputs
//   *_out              registered copies of the above
//   fresh              high for the first cycle a newly latched item is held
//   stall_cnt          consecutive hold cycles of the current item, saturating
//
// Action priority per edge: reset > req > bubble > en > hold.
// Every output comes straight from a flop; no input-to-output comb path.
module pipe_stage_reg #(
    parameter int          DATA_W   = 32,
    parameter int          N_DATA   = 3,
    parameter int          SIG_W    = 8,
    parameter int          CNT_W    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] FLUSH_PC = 32'h0000_4180
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     en,
    input  logic                     bubble,
    input  logic [31:0]              instr_in,
    input  logic [31:0]              PC_in,
    input  logic [N_DATA*DATA_W-1:0] data_in,
    input  logic [SIG_W-1:0]         sig_in,
    input  logic                     bd_in,
    input  logic [4:0]               exc_in,
    input  logic                     valid_in,
    output logic [31:0]              instr_out,
    output logic [31:0]              PC_out,
    output logic [N_DATA*DATA_W-1:0] data_out,
    output logic [SIG_W-1:0]         sig_out,
    output logic                     bd_out,
    output logic [4:0]               exc_out,
    output logic                     valid_out,
    output logic                     fresh,
    output logic [CNT_W-1:0]         stall_cnt
);

    typedef struct packed {
        logic [31:0]              instr;
        logic [31:0]              pc;
        logic [N_DATA*DATA_W-1:0] data;
        logic [SIG_W-1:0]         sig;
        logic                     bd;
        logic [4:0]               exc;
        logic                     valid;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    stage_t           in_s;
    stage_t           stage_d, stage_q;
    logic             fresh_d, fresh_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        in_s       = '0;
        in_s.instr = instr_in;
        in_s.pc    = PC_in;
        in_s.data  = data_in;
        in_s.sig   = sig_in;
        in_s.bd    = bd_in;
        in_s.exc   = exc_in;
        in_s.valid = valid_in;
    end

    // Next state. Default is hold: payload kept, counter counts up and
    // sticks at its maximum instead of wrapping.
    always_comb begin
        stage_d = stage_q;
        fresh_d = 1'b0;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (req) begin
            stage_d    = '0;
            stage_d.pc = FLUSH_PC;
            cnt_d      = '0;
        end else if (bubble) begin
            // NOP slot that still reports the stalled instruction's PC/BD,
            // so an EPC capture on the bubble is precise.
            stage_d    = '0;
            stage_d.pc = PC_in;
            stage_d.bd = bd_in;
            fresh_d    = 1'b1;
            cnt_d      = '0;
        end else if (en) begin
            stage_d = in_s;
            fresh_d = 1'b1;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q    <= '0;
            stage_q.pc <= RESET_PC;
            fresh_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            stage_q <= stage_d;
            fresh_q <= fresh_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_out = stage_q.instr;
    assign PC_out    = stage_q.pc;
    assign data_out  = stage_q.data;
    assign sig_out   = stage_q.sig;
    assign bd_out    = stage_q.bd;
    assign exc_out   = stage_q.exc;
    assign valid_out = stage_q.valid;
    assign fresh     = fresh_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. Two instances share stimulus: dut with
// default parameters and dut3 with CNT_W=3 for the saturation check.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, req, en, bubble, bd_in, valid_in;
    logic [31:0] instr_in, PC_in;
    logic [95:0] data_in;
    logic [7:0]  sig_in;
    logic [4:0]  exc_in;

    logic [31:0] instr_out, PC_out;
    logic [95:0] data_out;
    logic [7:0]  sig_out;
    logic        bd_out, valid_out, fresh;
    logic [4:0]  exc_out;
    logic [7:0]  stall_cnt;

    logic [31:0] instr_out3, PC_out3;
    logic [95:0] data_out3;
    logic [7:0]  sig_out3;
    logic        bd_out3, valid_out3, fresh3;
    logic [4:0]  exc_out3;
    logic [2:0]  stall_cnt3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .req(req), .en(en), .bubble(bubble),
        .instr_in(instr_in), .PC_in(PC_in), .data_in(data_in), .sig_in(sig_in),
        .bd_in(bd_in), .exc_in(exc_in), .valid_in(valid_in),
        .instr_out(instr_out), .PC_out(PC_out), .data_out(data_out),
        .sig_out(sig_out), .bd_out(bd_out), .exc_out(exc_out),
        .valid_out(valid_out), .fresh(fresh), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .req(req), .en(en), .bubble(bubble),
        .instr_in(instr_in), .PC_in(PC_in), .data_in(data_in), .sig_in(sig_in),
        .bd_in(bd_in), .exc_in(exc_in), .valid_in(valid_in),
        .instr_out(instr_out3), .PC_out(PC_out3), .data_out(data_out3),
        .sig_out(sig_out3), .bd_out(bd_out3), .exc_out(exc_out3),
        .valid_out(valid_out3), .fresh(fresh3), .stall_cnt(stall_cnt3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; req = 0; en = 1; bubble = 0;
        instr_in = 32'hDEADBEEF; PC_in = 32'h1234_5678;
        data_in = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        sig_in = 8'hA5; bd_in = 1; exc_in = 5'd7; valid_in = 1;
        step(); step();
        n_chk++; if (PC_out !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc got %h want 00003000", PC_out); end
        n_chk++; if (instr_out !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instr_out); end
        n_chk++; if (data_out !== 96'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", data_out); end
        n_chk++; if ({sig_out, bd_out, exc_out, valid_out} !== 15'h0) begin n_fail++; $display("FAIL reset_ctl got sig=%h bd=%b exc=%h v=%b want 0", sig_out, bd_out, exc_out, valid_out); end
        n_chk++; if (fresh !== 1'b0 || stall_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_fresh_cnt got %b/%0d want 0/0", fresh, stall_cnt); end
        n_chk++; if (PC_out3 !== 32'h0000_3000 || stall_cnt3 !== 3'd0) begin n_fail++; $display("FAIL reset_dut3 got %h/%0d want 00003000/0", PC_out3, stall_cnt3); end
    endtask

    task automatic test_advance_hold();
        reset = 0; en = 1;
        instr_in = 32'h8C01_0004; PC_in = 32'h0000_3004; valid_in = 1;
        bd_in = 0; exc_in = 5'd0; sig_in = 8'h3C;
        step();
        n_chk++; if (instr_out !== 32'h8C01_0004 || PC_out !== 32'h0000_3004) begin n_fail++; $display("FAIL adv_payload got %h/%h want 8c010004/00003004", instr_out, PC_out); end
        n_chk++; if (valid_out !== 1'b1 || sig_out !== 8'h3C) begin n_fail++; $display("FAIL adv_valid_sig got %b/%h want 1/3c", valid_out, sig_out); end
        n_chk++; if (fresh !== 1'b1 || stall_cnt !== 8'd0) begin n_fail++; $display("FAIL adv_fresh_cnt got %b/%0d want 1/0", fresh, stall_cnt); end
        en = 0; instr_in = 32'hFFFF_FFFF; PC_in = 32'hFFFF_FFFC; valid_in = 0;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_chk++; if (stall_cnt !== 8'(k) || fresh !== 1'b0) begin n_fail++; $display("FAIL hold_cnt[%0d] got %0d/%b want %0d/0", k, stall_cnt, fresh, k); end
            n_chk++; if (instr_out !== 32'h8C01_0004 || PC_out !== 32'h0000_3004 || valid_out !== 1'b1) begin n_fail++; $display("FAIL hold_payload[%0d] got %h/%h/%b", k, instr_out, PC_out, valid_out); end
        end
    endtask

    task automatic test_bubble();
        PC_in = 32'h0000_3010; bd_in = 1; instr_in = 32'h0022_1820;
        valid_in = 1; exc_in = 5'd3; sig_in = 8'hFF; data_in = {3{32'h5A5A_5A5A}};
        bubble = 1; en = 0;
        step();
        n_chk++; if (instr_out !== 32'h0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL bubble_nop got %h/%b want 0/0", instr_out, valid_out); end
        n_chk++; if (PC_out !== 32'h0000_3010 || bd_out !== 1'b1) begin n_fail++; $display("FAIL bubble_pc_bd got %h/%b want 00003010/1", PC_out, bd_out); end
        n_chk++; if (fresh !== 1'b1 || stall_cnt !== 8'd0) begin n_fail++; $display("FAIL bubble_fresh_cnt got %b/%0d want 1/0", fresh, stall_cnt); end
        n_chk++; if (exc_out !== 5'd0 || sig_out !== 8'h0 || data_out !== 96'h0) begin n_fail++; $display("FAIL bubble_clear got %h/%h/%h want 0", exc_out, sig_out, data_out); end
        // bubble wins over en
        PC_in = 32'h0000_3014; bd_in = 0; en = 1;
        step();
        n_chk++; if (PC_out !== 32'h0000_3014 || instr_out !== 32'h0 || valid_out !== 1'b0 || bd_out !== 1'b0) begin n_fail++; $display("FAIL bubble_over_en got %h/%h/%b/%b want 00003014/0/0/0", PC_out, instr_out, valid_out, bd_out); end
        bubble = 0; en = 0;
    endtask

    task automatic test_flush();
        step(); step();   // build up a stall count
        n_chk++; if (stall_cnt !== 8'd2) begin n_fail++; $display("FAIL flush_precnt got %0d want 2", stall_cnt); end
        req = 1; bubble = 1; en = 1; exc_in = 5'd4; bd_in = 1; valid_in = 1;
        step();
        n_chk++; if (PC_out !== 32'h0000_4180 || exc_out !== 5'd0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_main got %h/%h/%b want 00004180/0/0", PC_out, exc_out, valid_out); end
        n_chk++; if (stall_cnt !== 8'd0 || fresh !== 1'b0 || bd_out !== 1'b0 || instr_out !== 32'h0) begin n_fail++; $display("FAIL flush_misc got cnt=%0d fresh=%b bd=%b instr=%h want 0", stall_cnt, fresh, bd_out, instr_out); end
        req = 0; bubble = 0; en = 0;
    endtask

    task automatic test_saturation();
        en = 1; step(); en = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_chk++; if (stall_cnt3 !== 3'((k > 7) ? 7 : k)) begin n_fail++; $display("FAIL sat_cnt3[%0d] got %0d want %0d", k, stall_cnt3, (k > 7) ? 7 : k); end
        end
        n_chk++; if (stall_cnt !== 8'd10) begin n_fail++; $display("FAIL sat_cnt8 got %0d want 10", stall_cnt); end
        en = 1; step(); en = 0;
        n_chk++; if (stall_cnt3 !== 3'd0 || fresh3 !== 1'b1) begin n_fail++; $display("FAIL sat_clear got %0d/%b want 0/1", stall_cnt3, fresh3); end
    endtask

    task automatic test_channel_map();
        data_in = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        en = 1; step(); en = 0;
        n_chk++; if (data_out[31:0] !== 32'hAAAA_0001) begin n_fail++; $display("FAIL chan0 got %h want aaaa0001", data_out[31:0]); end
        n_chk++; if (data_out[63:32] !== 32'hBBBB_0002) begin n_fail++; $display("FAIL chan1 got %h want bbbb0002", data_out[63:32]); end
        n_chk++; if (data_out[95:64] !== 32'hCCCC_0003) begin n_fail++; $display("FAIL chan2 got %h want cccc0003", data_out[95:64]); end
    endtask

    task automatic test_back_to_back();
        en = 1; valid_in = 1; exc_in = 5'd9;
        for (int k = 0; k < 4; k++) begin
            instr_in = 32'h2000_0000 + 32'(k); PC_in = 32'h0000_3100 + 32'(4 * k);
            step();
            n_chk++; if (instr_out !== 32'h2000_0000 + 32'(k) || PC_out !== 32'h0000_3100 + 32'(4 * k)) begin n_fail++; $display("FAIL b2b_payload[%0d] got %h/%h", k, instr_out, PC_out); end
            n_chk++; if (fresh !== 1'b1 || stall_cnt !== 8'd0 || exc_out !== 5'd9) begin n_fail++; $display("FAIL b2b_ctl[%0d] got fresh=%b cnt=%0d exc=%0d want 1/0/9", k, fresh, stall_cnt, exc_out); end
        end
        en = 0;
    endtask

    task automatic test_reset_mid_stall();
        step(); step();
        n_chk++; if (stall_cnt !== 8'd2) begin n_fail++; $display("FAIL mid_precnt got %0d want 2", stall_cnt); end
        reset = 1; en = 1; step(); step();
        n_chk++; if (stall_cnt !== 8'd0 || PC_out !== 32'h0000_3000 || valid_out !== 1'b0 || fresh !== 1'b0) begin n_fail++; $display("FAIL mid_reset got cnt=%0d pc=%h v=%b fresh=%b", stall_cnt, PC_out, valid_out, fresh); end
        reset = 0; step();
        n_chk++; if (fresh !== 1'b1 || PC_out !== PC_in || valid_out !== 1'b1) begin n_fail++; $display("FAIL post_reset_en got fresh=%b pc=%h v=%b", fresh, PC_out, valid_out); end
        en = 0;
    endtask

    initial begin
        test_reset();
        test_advance_hold();
        test_bubble();
        test_flush();
        test_saturation();
        test_channel_map();
        test_back_to_back();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
